// File: rtl/demux64.sv
// One-to-four registered demultiplexer with per-channel valid/ack handshake.
// Invalid selects are dropped and tallied in a saturating error counter.
module demux64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       Sel,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    input  logic             err_clr,
    output logic             sel_err,
    output logic [7:0]       drop_cnt,
    output logic             busy
);

    logic [WIDTH-1:0] ch [4];
    logic [1:0]       idx;
    logic             bad_sel;
    logic             acc;
    logic             drop;
    logic [3:0]       load;

    assign idx     = Sel[1:0];
    assign bad_sel = Sel[2];

    // A full channel frees up the same cycle its consumer acks it
    assign in_ready = bad_sel | ~out_valid[idx] | out_ack[idx];
    assign acc      = in_valid & in_ready;
    assign drop     = acc & bad_sel;

    always_comb begin
        load = '0;
        if (acc && !bad_sel) begin
            load[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                ch[i] <= '0;
            end
            out_valid <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    ch[i]        <= Entrada;
                    out_valid[i] <= 1'b1;
                end else if (out_ack[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // A drop in the clearing cycle counts as the first of the new window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else if (err_clr) begin
            sel_err  <= drop;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            sel_err <= 1'b1;
            if (drop_cnt != 8'hff) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign A    = ch[0];
    assign B    = ch[1];
    assign C    = ch[2];
    assign D    = ch[3];
    assign busy = |out_valid;

endmodule

// File: tb/tb_demux64.sv
// Directed bench for demux64: handshake, drops, error clear and async reset.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_demux64;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  Sel;
    logic [63:0] Entrada;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A, B, C, D;
    logic [3:0]  out_valid;
    logic [3:0]  out_ack;
    logic        err_clr;
    logic        sel_err;
    logic [7:0]  drop_cnt;
    logic        busy;

    int cmp = 0;
    int mis = 0;

    demux64 #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .Sel(Sel), .Entrada(Entrada),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid), .out_ack(out_ack), .err_clr(err_clr),
        .sel_err(sel_err), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; Sel = 3'd0; Entrada = '0; in_valid = 1'b0;
        out_ack = 4'b0000; err_clr = 1'b0;
        #12;
        chk("rst_A", A, 0); chk("rst_B", B, 0);
        chk("rst_C", C, 0); chk("rst_D", D, 0);
        chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0);
        chk("rst_err", sel_err, 0); chk("rst_cnt", drop_cnt, 0);
        chk("rst_ready", in_ready, 1);

        // first edge after release accepts
        reset = 1'b1;
        Sel = 3'd2; Entrada = 64'h1234; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("c_load", C, 64'h1234); chk("c_valid", out_valid, 4'b0100);
        chk("c_A", A, 0); chk("c_B", B, 0); chk("c_D", D, 0);
        chk("c_busy", busy, 1);

        // channel 0 backpressure then ack + reload
        Sel = 3'd0; Entrada = 64'hAAAA; in_valid = 1'b1;
        tick();
        chk("a_load", A, 64'hAAAA);
        Entrada = 64'h5555; #1;
        chk("a_full_ready", in_ready, 0);
        tick();
        chk("a_hold", A, 64'hAAAA);
        out_ack = 4'b0001; Entrada = 64'hBEEF; #1;
        chk("a_ack_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; out_ack = 4'b0000;
        chk("a_b2b", A, 64'hBEEF); chk("a_b2b_valid", out_valid, 4'b0101);

        // ack to an empty channel is ignored
        out_ack = 4'b0010;
        tick();
        out_ack = 4'b0000;
        chk("ack_empty", out_valid, 4'b0101);

        // 300 invalid-select drops saturate at 255
        Sel = 3'd5; Entrada = 64'hDEAD; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            chk("drop_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("drop_valid", out_valid, 4'b0101);
        chk("drop_A", A, 64'hBEEF); chk("drop_C", C, 64'h1234);
        chk("drop_err", sel_err, 1); chk("drop_sat", drop_cnt, 255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", sel_err, 0); chk("clr_cnt", drop_cnt, 0);

        // clear coinciding with a drop
        Sel = 3'd6; in_valid = 1'b1;
        repeat (9) tick();
        chk("cnt9", drop_cnt, 9);
        Sel = 3'd7; err_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("clrdrop_err", sel_err, 1); chk("clrdrop_cnt", drop_cnt, 1);

        // fill all four, then ack all together
        out_ack = 4'b1111;
        tick();
        out_ack = 4'b0000;
        chk("flush", out_valid, 4'b0000);
        in_valid = 1'b1;
        Sel = 3'd0; Entrada = 64'h11; tick();
        Sel = 3'd1; Entrada = 64'h22; tick();
        Sel = 3'd2; Entrada = 64'h33; tick();
        Sel = 3'd3; Entrada = 64'h44; tick();
        in_valid = 1'b0;
        chk("all_valid", out_valid, 4'b1111);
        out_ack = 4'b1111;
        tick();
        out_ack = 4'b0000;
        chk("all_ack", out_valid, 4'b0000); chk("all_busy", busy, 0);
        chk("all_A", A, 64'h11); chk("all_B", B, 64'h22);
        chk("all_C", C, 64'h33); chk("all_D", D, 64'h44);

        // back-to-back on channel 1 while channel 0 gets an idle ack
        Sel = 3'd1; Entrada = 64'h55; in_valid = 1'b1;
        tick();
        Entrada = 64'h66; out_ack = 4'b0011;
        tick();
        out_ack = 4'b0000;
        chk("b2b_B", B, 64'h66); chk("b2b_valid", out_valid, 4'b0010);
        chk("b2b_A", A, 64'h11);

        // mid-cycle reset with channels 1 and 3 full
        Sel = 3'd3; Entrada = 64'h77;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 4'b1010);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0); chk("mid_rst_B", B, 0);
        chk("mid_rst_D", D, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        #1 reset = 1'b1;
        Entrada = 64'h99; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_D", D, 64'h99); chk("post_rst_valid", out_valid, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
